// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: datapath width, instruction
// alignment, default reset PC, and the fetch FSM state encoding.
package core_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned INSTR_ALIGN_BITS = 2;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned     DEFAULT_PC_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    // Force an address onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};
    endfunction

    // True when an address does not sit on an instruction boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return |addr[INSTR_ALIGN_BITS-1:0];
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory request/response channels plus the
// instruction hand-off channel to decode.
interface pc_fetch_sequencer_if;
    import core_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    // View of the fetch sequencer.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    // View of the memory and decode side.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// Architectural program counter. Selects between hold, sequential advance
// and branch redirect (redirect wins), and flags misaligned branch targets.
// next_pc is exposed combinationally so the fetch FSM can launch the
// following request from the same edge that updates the PC.
module pc_reg
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    input  logic [XLEN-1:0] base,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign_err
);

    logic [XLEN-1:0] pc;

    // Next-PC select: redirect has priority over the sequential step.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = align_pc(target);
        end else if (advance) begin
            next_pc = base + XLEN'(PC_STEP);
        end
    end

    // PC register and one-cycle misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            pc           <= next_pc;
            misalign_err <= redirect && is_misaligned(target);
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the PC, keeps one instruction-memory request in
// flight, and hands fetched words plus their PC to decode. A branch that
// lands while a fetch is in flight sets kill so the stale response is
// dropped and the fetch restarts at the redirected PC.
module pc_fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pc_fetch_sequencer_if.master      fetch,
    input  logic                      branch_taken,
    input  logic [XLEN-1:0]           branch_target,
    output logic                      misalign_err
);

    fetch_state_e    state;
    logic [XLEN-1:0] req_addr;
    logic            req_valid;
    logic            kill;
    logic            instr_valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] next_pc;
    logic            advance;

    // Sequential step only when decode takes the held instruction.
    assign advance = (state == HOLD) && fetch.instr_ready;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (branch_taken),
        .target       (branch_target),
        .advance      (advance),
        .base         (instr_pc_q),
        .next_pc      (next_pc),
        .misalign_err (misalign_err)
    );

    assign fetch.imem_req_valid = req_valid;
    assign fetch.imem_req_addr  = req_addr;
    assign fetch.instr_valid    = instr_valid_q;
    assign fetch.instr          = instr_q;
    assign fetch.instr_pc       = instr_pc_q;

    // Fetch FSM with registered request and decode-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_addr      <= RESET_PC;
            req_valid     <= 1'b0;
            kill          <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_addr  <= next_pc;
                    req_valid <= 1'b1;
                    state     <= REQ;
                end
                REQ: begin
                    // Address stays put while stalled; a redirect only marks
                    // the in-flight fetch for discard.
                    if (branch_taken) begin
                        kill <= 1'b1;
                    end
                    if (fetch.imem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fetch.imem_rsp_valid) begin
                        if (kill || branch_taken) begin
                            kill      <= 1'b0;
                            req_addr  <= next_pc;
                            req_valid <= 1'b1;
                            state     <= REQ;
                        end else begin
                            instr_q       <= fetch.imem_rsp_data;
                            instr_pc_q    <= req_addr;
                            instr_valid_q <= 1'b1;
                            state         <= HOLD;
                        end
                    end else if (branch_taken) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // next_pc is either the redirect target or instr_pc + step.
                    if (branch_taken || fetch.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        req_addr      <= next_pc;
                        req_valid     <= 1'b1;
                        state         <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
